// File: rtl/alu_operand_stack.sv
// Operand stack feeding the ALU: LIFO of cells with push/pop/ALU commands.
// ALU commands pop NOS/TOS into the ALU input registers and push the result back.
module alu_operand_stack #(
    parameter int CELL_SIZE = 16,
    parameter int DEPTH     = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_kind,
    input  logic [2:0]               cmd_op,
    input  logic [CELL_SIZE-1:0]     cmd_data,
    output logic                     pop_valid,
    output logic [CELL_SIZE-1:0]     pop_data,
    output logic [2:0]               alu_op,
    output logic [CELL_SIZE-1:0]     alu_lhs,
    output logic [CELL_SIZE-1:0]     alu_rhs,
    input  logic [CELL_SIZE-1:0]     alu_result,
    output logic [CELL_SIZE-1:0]     top,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     err_valid,
    output logic [1:0]               err_code
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;
    localparam logic [DW-1:0] FULL = DW'(DEPTH);

    localparam logic [1:0] KIND_PUSH = 2'b00;
    localparam logic [1:0] KIND_POP  = 2'b01;
    localparam logic [1:0] KIND_ALU  = 2'b10;

    localparam logic [1:0] ERR_UNDER = 2'b01;
    localparam logic [1:0] ERR_OVER  = 2'b10;
    localparam logic [1:0] ERR_DIV0  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t state_r;
    state_t state_s;

    logic [CELL_SIZE-1:0] mem [DEPTH];

    logic [AW-1:0]        nos_idx_s;
    logic [AW-1:0]        third_idx_s;
    logic [CELL_SIZE-1:0] nos_val_s;
    logic [CELL_SIZE-1:0] third_val_s;
    logic                 accept_s;
    logic                 alu_under_s;
    logic                 alu_div0_s;
    logic                 alu_issue_s;
    logic                 wr_en_s;
    logic [AW-1:0]        wr_idx_s;
    logic [CELL_SIZE-1:0] wr_data_s;

    assign cmd_ready   = (state_r == S_IDLE);
    assign nos_idx_s   = AW'(depth - DW'(2));
    assign third_idx_s = AW'(depth - DW'(3));
    assign nos_val_s   = mem[nos_idx_s];
    assign third_val_s = mem[third_idx_s];

    // Command decode and ALU pre-issue error checks (TOS is the registered top).
    always_comb begin
        accept_s    = cmd_valid && cmd_ready;
        alu_under_s = (depth < DW'(2));
        alu_div0_s  = 1'b0;
        if (!alu_under_s && ((cmd_op == 3'b011) || (cmd_op == 3'b100))) begin
            alu_div0_s = (top == {CELL_SIZE{1'b0}});
        end else begin
            alu_div0_s = 1'b0;
        end
        alu_issue_s = accept_s && (cmd_kind == KIND_ALU) && !alu_under_s && !alu_div0_s;
    end

    // Next-state logic for the issue / wait / write-back sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE:  state_s = alu_issue_s ? S_WAIT : S_IDLE;
            S_WAIT:  state_s = S_WB;
            S_WB:    state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Storage write port: accepted push in IDLE, or ALU result in WB.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_idx_s  = depth[AW-1:0];
        wr_data_s = cmd_data;
        if ((state_r == S_IDLE) && accept_s && (cmd_kind == KIND_PUSH) && (depth != FULL)) begin
            wr_en_s = 1'b1;
        end else if (state_r == S_WB) begin
            wr_en_s   = 1'b1;
            wr_data_s = alu_result;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Stack storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (reset_n && wr_en_s) begin
            mem[wr_idx_s] <= wr_data_s;
        end
    end

    // Depth, registered TOS, pop/error pulses and ALU input registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            depth     <= {DW{1'b0}};
            top       <= {CELL_SIZE{1'b0}};
            pop_valid <= 1'b0;
            pop_data  <= {CELL_SIZE{1'b0}};
            alu_op    <= 3'b000;
            alu_lhs   <= {CELL_SIZE{1'b0}};
            alu_rhs   <= {CELL_SIZE{1'b0}};
            err_valid <= 1'b0;
            err_code  <= 2'b00;
        end else begin
            pop_valid <= 1'b0;
            err_valid <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        case (cmd_kind)
                            KIND_PUSH: begin
                                if (depth == FULL) begin
                                    err_valid <= 1'b1;
                                    err_code  <= ERR_OVER;
                                end else begin
                                    depth <= depth + DW'(1);
                                    top   <= cmd_data;
                                end
                            end
                            KIND_POP: begin
                                if (depth == DW'(0)) begin
                                    err_valid <= 1'b1;
                                    err_code  <= ERR_UNDER;
                                end else begin
                                    pop_valid <= 1'b1;
                                    pop_data  <= top;
                                    depth     <= depth - DW'(1);
                                    top       <= (depth >= DW'(2)) ? nos_val_s : {CELL_SIZE{1'b0}};
                                end
                            end
                            KIND_ALU: begin
                                if (alu_under_s) begin
                                    err_valid <= 1'b1;
                                    err_code  <= ERR_UNDER;
                                end else if (alu_div0_s) begin
                                    err_valid <= 1'b1;
                                    err_code  <= ERR_DIV0;
                                end else begin
                                    alu_lhs <= nos_val_s;
                                    alu_rhs <= top;
                                    alu_op  <= cmd_op;
                                    depth   <= depth - DW'(2);
                                    top     <= (depth >= DW'(3)) ? third_val_s : {CELL_SIZE{1'b0}};
                                end
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                S_WB: begin
                    depth <= depth + DW'(1);
                    top   <= alu_result;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_operand_stack.sv
// Self-checking bench for alu_operand_stack; the bench models the ALU and
// keeps expected pop/ALU results in a scoreboard queue.
module tb_alu_operand_stack;

    localparam int CS    = 16;
    localparam int DEPTH = 16;
    localparam int DW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_kind;
    logic [2:0]    cmd_op;
    logic [CS-1:0] cmd_data;
    logic          pop_valid;
    logic [CS-1:0] pop_data;
    logic [2:0]    alu_op;
    logic [CS-1:0] alu_lhs;
    logic [CS-1:0] alu_rhs;
    logic [CS-1:0] alu_result;
    logic [CS-1:0] top;
    logic [DW-1:0] depth;
    logic          err_valid;
    logic [1:0]    err_code;

    int n_cmp = 0;
    int n_bad = 0;
    logic [CS-1:0] exp_q [$];

    alu_operand_stack #(.CELL_SIZE(CS), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_kind(cmd_kind), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .pop_valid(pop_valid), .pop_data(pop_data),
        .alu_op(alu_op), .alu_lhs(alu_lhs), .alu_rhs(alu_rhs),
        .alu_result(alu_result),
        .top(top), .depth(depth),
        .err_valid(err_valid), .err_code(err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CS-1:0] alu_ref(input logic [2:0] op, input logic [CS-1:0] a, input logic [CS-1:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a * b;
            3'd3:    return (b == 16'd0) ? 16'd0 : a / b;
            3'd4:    return (b == 16'd0) ? 16'd0 : a % b;
            3'd5:    return a & b;
            3'd6:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    // The ALU itself: one registered stage behind the DUT's input registers.
    always @(posedge clk) alu_result <= alu_ref(alu_op, alu_lhs, alu_rhs);

    task automatic issue(input logic [1:0] k, input logic [2:0] op, input logic [CS-1:0] d);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_kind = k; cmd_op = op; cmd_data = d;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_kind = 2'd0; cmd_op = 3'd0; cmd_data = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({depth, top, pop_valid, pop_data, err_valid, err_code} !== {DW'(0), 16'd0, 1'b0, 16'd0, 1'b0, 2'd0}) begin
            n_bad++; $display("FAIL reset_outputs: got depth=%0d top=%h pv=%b pd=%h ev=%b ec=%b, want all 0",
                              depth, top, pop_valid, pop_data, err_valid, err_code);
        end
        n_cmp++;
        if ({alu_op, alu_lhs, alu_rhs} !== {3'd0, 16'd0, 16'd0}) begin
            n_bad++; $display("FAIL reset_alu: got op=%0d lhs=%h rhs=%h, want 0", alu_op, alu_lhs, alu_rhs);
        end
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_alu_basic();
        logic [CS-1:0] e;
        issue(2'b00, 3'd0, 16'd7);
        issue(2'b00, 3'd0, 16'd3);
        exp_q.push_back(alu_ref(3'd1, 16'd7, 16'd3));
        issue(2'b10, 3'd1, 16'd0);
        n_cmp++;
        if ({alu_lhs, alu_rhs, alu_op} !== {16'd7, 16'd3, 3'd1}) begin
            n_bad++; $display("FAIL basic_issue: got lhs=%0d rhs=%0d op=%0d want 7 3 1", alu_lhs, alu_rhs, alu_op);
        end
        n_cmp++;
        if ({depth, cmd_ready} !== {DW'(0), 1'b0}) begin
            n_bad++; $display("FAIL basic_wait: got depth=%0d ready=%b want 0 0", depth, cmd_ready);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({depth, cmd_ready} !== {DW'(0), 1'b0}) begin
            n_bad++; $display("FAIL basic_wb: got depth=%0d ready=%b want 0 0", depth, cmd_ready);
        end
        @(posedge clk); #1;
        e = exp_q.pop_front();
        n_cmp++;
        if ({depth, top, cmd_ready} !== {DW'(1), e, 1'b1}) begin
            n_bad++; $display("FAIL basic_result: got depth=%0d top=%0d ready=%b want 1 %0d 1", depth, top, cmd_ready, e);
        end
        exp_q.push_back(16'd4);
        issue(2'b01, 3'd0, 16'd0);
        e = exp_q.pop_front();
        n_cmp++;
        if ({pop_valid, pop_data, depth} !== {1'b1, e, DW'(0)}) begin
            n_bad++; $display("FAIL basic_pop: got pv=%b data=%0d depth=%0d want 1 %0d 0", pop_valid, pop_data, depth, e);
        end
    endtask

    task automatic test_alu_table();
        logic [CS-1:0] ta [8] = '{16'd100, 16'd9, 16'd300, 16'd17, 16'd17, 16'hF0F0, 16'hF0F0, 16'hF0F0};
        logic [CS-1:0] tb [8] = '{16'd23,  16'd4, 16'd7,   16'd5,  16'd5,  16'h3C3C, 16'h3C3C, 16'h3C3C};
        logic [CS-1:0] e;
        for (int i = 0; i < 8; i++) begin
            issue(2'b00, 3'd0, ta[i]);
            issue(2'b00, 3'd0, tb[i]);
            exp_q.push_back(alu_ref(3'(i), ta[i], tb[i]));
            issue(2'b10, 3'(i), 16'd0);
            repeat (2) begin @(posedge clk); #1; end
            e = exp_q.pop_front();
            n_cmp++;
            if ({depth, top} !== {DW'(1), e}) begin
                n_bad++; $display("FAIL table_op%0d: got depth=%0d top=%h want 1 %h", i, depth, top, e);
            end
            exp_q.push_back(e);
            issue(2'b01, 3'd0, 16'd0);
            e = exp_q.pop_front();
            n_cmp++;
            if ({pop_valid, pop_data} !== {1'b1, e}) begin
                n_bad++; $display("FAIL table_pop%0d: got pv=%b data=%h want 1 %h", i, pop_valid, pop_data, e);
            end
        end
    endtask

    task automatic test_alu_underflow();
        issue(2'b00, 3'd0, 16'd9);
        issue(2'b10, 3'd0, 16'd0);
        n_cmp++;
        if ({err_valid, err_code, depth, top, cmd_ready} !== {1'b1, 2'b01, DW'(1), 16'd9, 1'b1}) begin
            n_bad++; $display("FAIL alu_under: got ev=%b ec=%b depth=%0d top=%0d ready=%b want 1 01 1 9 1",
                              err_valid, err_code, depth, top, cmd_ready);
        end
        n_cmp++;
        if ({alu_op, alu_lhs, alu_rhs} !== {3'd7, 16'hF0F0, 16'h3C3C}) begin
            n_bad++; $display("FAIL alu_under_regs: got op=%0d lhs=%h rhs=%h want 7 f0f0 3c3c", alu_op, alu_lhs, alu_rhs);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({err_valid, err_code, depth, cmd_ready} !== {1'b0, 2'b01, DW'(1), 1'b1}) begin
            n_bad++; $display("FAIL alu_under_after: got ev=%b ec=%b depth=%0d ready=%b want 0 01 1 1",
                              err_valid, err_code, depth, cmd_ready);
        end
        issue(2'b01, 3'd0, 16'd0);
    endtask

    task automatic test_div0();
        logic [2:0] ops [2] = '{3'b011, 3'b100};
        issue(2'b00, 3'd0, 16'h0005);
        issue(2'b00, 3'd0, 16'h0000);
        for (int i = 0; i < 2; i++) begin
            issue(2'b10, ops[i], 16'd0);
            n_cmp++;
            if ({err_valid, err_code, depth, top, cmd_ready} !== {1'b1, 2'b11, DW'(2), 16'd0, 1'b1}) begin
                n_bad++; $display("FAIL div0_op%0d: got ev=%b ec=%b depth=%0d top=%0d ready=%b want 1 11 2 0 1",
                                  ops[i], err_valid, err_code, depth, top, cmd_ready);
            end
            n_cmp++;
            if ({alu_op, alu_lhs, alu_rhs} !== {3'd7, 16'hF0F0, 16'h3C3C}) begin
                n_bad++; $display("FAIL div0_regs%0d: got op=%0d lhs=%h rhs=%h want 7 f0f0 3c3c", ops[i], alu_op, alu_lhs, alu_rhs);
            end
            @(posedge clk); #1;
            n_cmp++;
            if ({err_valid, err_code} !== {1'b0, 2'b11}) begin
                n_bad++; $display("FAIL div0_hold%0d: got ev=%b ec=%b want 0 11", ops[i], err_valid, err_code);
            end
        end
        issue(2'b01, 3'd0, 16'd0);
        issue(2'b01, 3'd0, 16'd0);
        n_cmp++;
        if ({pop_valid, pop_data, depth} !== {1'b1, 16'h0005, DW'(0)}) begin
            n_bad++; $display("FAIL div0_cleanup: got pv=%b data=%h depth=%0d want 1 0005 0", pop_valid, pop_data, depth);
        end
    endtask

    task automatic test_overflow();
        logic [CS-1:0] e;
        for (int i = 1; i <= DEPTH; i++) issue(2'b00, 3'd0, 16'(i));
        n_cmp++;
        if ({depth, top} !== {DW'(DEPTH), 16'(DEPTH)}) begin
            n_bad++; $display("FAIL full: got depth=%0d top=%0d want %0d %0d", depth, top, DEPTH, DEPTH);
        end
        issue(2'b00, 3'd0, 16'hAAAA);
        n_cmp++;
        if ({err_valid, err_code, depth, top} !== {1'b1, 2'b10, DW'(DEPTH), 16'(DEPTH)}) begin
            n_bad++; $display("FAIL overflow: got ev=%b ec=%b depth=%0d top=%h want 1 10 %0d %0d",
                              err_valid, err_code, depth, top, DEPTH, DEPTH);
        end
        for (int i = DEPTH; i >= 1; i--) exp_q.push_back(16'(i));
        for (int i = 0; i < DEPTH; i++) begin
            issue(2'b01, 3'd0, 16'd0);
            e = exp_q.pop_front();
            n_cmp++;
            if ({pop_valid, pop_data} !== {1'b1, e}) begin
                n_bad++; $display("FAIL drain_pop%0d: got pv=%b data=%0d want 1 %0d", i, pop_valid, pop_data, e);
            end
        end
        issue(2'b01, 3'd0, 16'd0);
        n_cmp++;
        if ({err_valid, err_code, pop_valid, depth, top} !== {1'b1, 2'b01, 1'b0, DW'(0), 16'd0}) begin
            n_bad++; $display("FAIL pop_under: got ev=%b ec=%b pv=%b depth=%0d top=%0d want 1 01 0 0 0",
                              err_valid, err_code, pop_valid, depth, top);
        end
    endtask

    task automatic test_reset_in_wait();
        issue(2'b00, 3'd0, 16'd2);
        issue(2'b00, 3'd0, 16'd3);
        issue(2'b10, 3'd2, 16'd0);
        reset_n = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({depth, top, pop_valid, pop_data, err_valid, err_code, alu_op, alu_lhs, alu_rhs}
            !== {DW'(0), 16'd0, 1'b0, 16'd0, 1'b0, 2'd0, 3'd0, 16'd0, 16'd0}) begin
            n_bad++; $display("FAIL wait_reset: got depth=%0d top=%h pd=%h ec=%b op=%0d lhs=%h rhs=%h want all 0",
                              depth, top, pop_data, err_code, alu_op, alu_lhs, alu_rhs);
        end
        reset_n = 1'b1;
        issue(2'b00, 3'd0, 16'd1);
        n_cmp++;
        if ({depth, top, cmd_ready} !== {DW'(1), 16'd1, 1'b1}) begin
            n_bad++; $display("FAIL wait_reset_push: got depth=%0d top=%0d ready=%b want 1 1 1", depth, top, cmd_ready);
        end
        repeat (2) begin @(posedge clk); #1; end
        n_cmp++;
        if ({depth, top} !== {DW'(1), 16'd1}) begin
            n_bad++; $display("FAIL wait_reset_nowb: got depth=%0d top=%0d want 1 1", depth, top);
        end
        issue(2'b01, 3'd0, 16'd0);
    endtask

    task automatic test_back_to_back();
        int acc_n;
        int acc_at [4];
        logic rdy;
        logic [CS-1:0] e;
        acc_n = 0;
        issue(2'b00, 3'd0, 16'd4);
        issue(2'b00, 3'd0, 16'd6);
        issue(2'b00, 3'd0, 16'd1);
        exp_q.push_back(alu_ref(3'd0, 16'd4, alu_ref(3'd0, 16'd6, 16'd1)));
        @(negedge clk);
        cmd_valid = 1'b1; cmd_kind = 2'b10; cmd_op = 3'd0; cmd_data = 16'd0;
        for (int k = 0; k < 4; k++) begin
            rdy = cmd_ready;
            @(posedge clk);
            if (rdy) begin acc_at[acc_n] = k; acc_n++; end
            if (k < 3) @(negedge clk);
        end
        #1 cmd_valid = 1'b0;
        n_cmp++;
        if (acc_n !== 2) begin
            n_bad++; $display("FAIL b2b_accepts: got %0d want 2", acc_n);
        end else begin
            n_cmp++;
            if ((acc_at[0] !== 0) || (acc_at[1] !== 3)) begin
                n_bad++; $display("FAIL b2b_timing: got cycles %0d,%0d want 0,3", acc_at[0], acc_at[1]);
            end
        end
        repeat (2) begin @(posedge clk); #1; end
        e = exp_q.pop_front();
        n_cmp++;
        if ({depth, top, cmd_ready} !== {DW'(1), e, 1'b1}) begin
            n_bad++; $display("FAIL b2b_result: got depth=%0d top=%0d ready=%b want 1 %0d 1", depth, top, cmd_ready, e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_alu_basic();
        test_alu_table();
        test_alu_underflow();
        test_div0();
        test_overflow();
        test_reset_in_wait();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
